// File: rtl/rgb_packet_unpacker.sv
// rgb_packet_unpacker: replays a packet of PIXELS packed RGB pixels as a
// pixel stream, pixel 0 (LSBs) first, one pixel per accepted output cycle.
// The next packet can be taken on the same edge the last pixel leaves, so
// back-to-back packets stream with no bubble.
module rgb_packet_unpacker #(
  parameter  int PIXELS = 128,
  parameter  int PIX_W  = 24,
  localparam int PKT_W  = PIXELS * PIX_W,
  localparam int IDX_W  = $clog2(PIXELS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PKT_W-1:0] data_in,
  input  logic             valid_in,
  output logic             ready_in,
  output logic [7:0]       R,
  output logic [7:0]       G,
  output logic [7:0]       B,
  output logic             valid_out,
  input  logic             ready_out,
  output logic             first_out,
  output logic             last_out,
  output logic [IDX_W-1:0] pix_idx,
  output logic [15:0]      pkt_count
);

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PIXELS - 1);

  state_t           state_q, state_d;
  logic [PKT_W-1:0] buf_q;
  logic [IDX_W-1:0] idx_q;
  logic [15:0]      pkt_cnt_q;

  logic last_pix;
  logic pix_acc;
  logic pkt_acc;

  // Handshake decode: the only input-to-output combinational path is
  // ready_out -> ready_in, which enables the zero-bubble handoff.
  assign valid_out = (state_q == STREAM);
  assign last_pix  = (idx_q == LAST_IDX);
  assign pix_acc   = valid_out & ready_out;
  assign ready_in  = (state_q == IDLE) | (last_pix & pix_acc);
  assign pkt_acc   = valid_in & ready_in;

  // Next-state logic: leave STREAM only when the last pixel goes out and no
  // new packet is handed over on the same edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (pkt_acc) state_d = STREAM;
      STREAM:  if (pix_acc && last_pix && !pkt_acc) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Pixel buffer: load on packet accept, otherwise shift one pixel out per
  // pixel accept. The final shift empties it, so IDLE shows zero pixels.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the buffer is a register bank, not a RAM, and it drives R/G/B
    // directly, so it is reset to give defined outputs straight out of reset.
    if (rst)          buf_q <= '0;
    else if (pkt_acc) buf_q <= data_in;
    else if (pix_acc) buf_q <= buf_q >> PIX_W;
  end

  // Pixel index: restarts on load and after the last pixel, else counts up.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      idx_q <= '0;
    else if (pkt_acc)             idx_q <= '0;
    else if (pix_acc && last_pix) idx_q <= '0;
    else if (pix_acc)             idx_q <= idx_q + 1'b1;
  end

  // Completed-packet counter, wraps naturally at 16 bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                      pkt_cnt_q <= '0;
    else if (pix_acc && last_pix) pkt_cnt_q <= pkt_cnt_q + 16'd1;
  end

  assign R         = buf_q[23:16];
  assign G         = buf_q[15:8];
  assign B         = buf_q[7:0];
  assign pix_idx   = idx_q;
  assign pkt_count = pkt_cnt_q;
  assign first_out = valid_out & (idx_q == '0);
  assign last_out  = valid_out & last_pix;

endmodule

// File: tb/tb_rgb_packet_unpacker.sv
// Testbench for rgb_packet_unpacker: a short vector table for the first
// handshake cycles, directed sequences for the multi-cycle corner cases, and
// random traffic, all checked against a pixel-queue reference model.
module tb_rgb_packet_unpacker;

  localparam int PIXELS = 128;
  localparam int PIX_W  = 24;
  localparam int PKT_W  = PIXELS * PIX_W;

  logic             clk = 1'b0;
  logic             rst;
  logic [PKT_W-1:0] data_in;
  logic             valid_in;
  logic             ready_in;
  logic [7:0]       R, G, B;
  logic             valid_out;
  logic             ready_out;
  logic             first_out;
  logic             last_out;
  logic [6:0]       pix_idx;
  logic [15:0]      pkt_count;

  rgb_packet_unpacker dut (
    .clk       (clk),
    .rst       (rst),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_in  (ready_in),
    .R         (R),
    .G         (G),
    .B         (B),
    .valid_out (valid_out),
    .ready_out (ready_out),
    .first_out (first_out),
    .last_out  (last_out),
    .pix_idx   (pix_idx),
    .pkt_count (pkt_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the pixels still owed to the consumer, in order.
  typedef struct {
    logic [23:0] pix;
    int          idx;
  } pix_t;

  pix_t        q[$];
  logic [15:0] model_cnt;

  function automatic logic [PKT_W-1:0] make_pattern();
    logic [PKT_W-1:0] p;
    logic [7:0]       b;
    for (int i = 0; i < PIXELS; i++) begin
      b = 8'(i);
      p[i*PIX_W +: PIX_W] = {b, ~b, 8'hA5};
    end
    return p;
  endfunction

  function automatic logic [PKT_W-1:0] make_const(input logic [23:0] v);
    logic [PKT_W-1:0] p;
    for (int i = 0; i < PIXELS; i++) p[i*PIX_W +: PIX_W] = v;
    return p;
  endfunction

  function automatic logic [PKT_W-1:0] make_random();
    logic [PKT_W-1:0] p;
    for (int i = 0; i < PKT_W / 32; i++) p[i*32 +: 32] = $urandom;
    return p;
  endfunction

  // One cycle: drive inputs at the falling edge, check outputs against the
  // model, then advance the model by what happens at the next rising edge.
  task automatic step(input logic vin, input logic [PKT_W-1:0] d,
                      input logic rdy, output logic acc);
    pix_t e;
    logic ev, erin, pacc;
    valid_in  = vin;
    data_in   = d;
    ready_out = rdy;
    #1;
    ev   = (q.size() != 0);
    erin = (q.size() == 0) || (q.size() == 1 && rdy);
    check("valid_out", 32'(valid_out), 32'(ev));
    check("ready_in", 32'(ready_in), 32'(erin));
    check("pkt_count", 32'(pkt_count), 32'(model_cnt));
    if (ev) begin
      e = q[0];
      check("R", 32'(R), 32'(e.pix[23:16]));
      check("G", 32'(G), 32'(e.pix[15:8]));
      check("B", 32'(B), 32'(e.pix[7:0]));
      check("pix_idx", 32'(pix_idx), 32'(e.idx));
      check("first_out", 32'(first_out), 32'(e.idx == 0));
      check("last_out", 32'(last_out), 32'(e.idx == PIXELS - 1));
    end else begin
      check("first_out idle", 32'(first_out), 32'd0);
      check("last_out idle", 32'(last_out), 32'd0);
    end
    pacc = ev && rdy;
    acc  = vin && erin;
    if (pacc) begin
      void'(q.pop_front());
      if (e.idx == PIXELS - 1) model_cnt++;
    end
    if (acc)
      for (int i = 0; i < PIXELS; i++) q.push_back('{pix: d[i*PIX_W +: PIX_W], idx: i});
    @(negedge clk);
  endtask

  // Reset held across two falling edges; outputs checked while asserted.
  task automatic do_reset();
    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("rst valid_out", 32'(valid_out), 32'd0);
    check("rst ready_in", 32'(ready_in), 32'd1);
    check("rst RGB", 32'({R, G, B}), 32'd0);
    check("rst pix_idx", 32'(pix_idx), 32'd0);
    check("rst pkt_count", 32'(pkt_count), 32'd0);
    rst = 1'b0;
    q.delete();
    model_cnt = '0;
  endtask

  // Step with valid_in held on packet d until accepted, bounded.
  task automatic send_held(input logic [PKT_W-1:0] d, input logic rdy);
    logic acc;
    int   n;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 400) begin
      step(1'b1, d, rdy, acc);
      n++;
    end
    check("send_held accepted", 32'(acc), 32'd1);
  endtask

  // Idle-input steps until the model's current pixel is idx, bounded.
  task automatic run_to_idx(input int idx);
    logic acc;
    int   n;
    n = 0;
    while ((q.size() == 0 || q[0].idx != idx) && n < 400) begin
      step(1'b0, '0, 1'b1, acc);
      n++;
    end
    check("run_to_idx reached", 32'(n < 400), 32'd1);
  endtask

  task automatic run_idle(input int cycles, input logic toggle);
    logic acc;
    for (int i = 0; i < cycles; i++)
      step(1'b0, '0, toggle ? logic'(i % 2 == 0) : 1'b1, acc);
  endtask

  typedef struct {
    logic       vin;
    logic       rdy;
    logic       exp_rin;
    logic       exp_vout;
    logic       exp_first;
    logic       exp_last;
    logic [6:0] exp_idx;
    logic [7:0] exp_r;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic             acc;
    logic             hv;
    logic [PKT_W-1:0] hd;

    vecs[0] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0};
    vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 7'd0, 8'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 8'd0};
    vecs[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 7'd0, 8'd0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd1, 8'd1};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 8'd2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 7'd2, 8'd2};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 7'd3, 8'd3};

    rst       = 1'b1;
    valid_in  = 1'b0;
    ready_out = 1'b0;
    data_in   = '0;
    model_cnt = '0;
    @(negedge clk);
    do_reset();

    // Vector table: first cycles of the test-pattern packet.
    for (int i = 0; i < 8; i++) begin
      valid_in  = vecs[i].vin;
      ready_out = vecs[i].rdy;
      data_in   = make_pattern();
      #1;
      check($sformatf("vec%0d ready_in", i), 32'(ready_in), 32'(vecs[i].exp_rin));
      check($sformatf("vec%0d valid_out", i), 32'(valid_out), 32'(vecs[i].exp_vout));
      check($sformatf("vec%0d first_out", i), 32'(first_out), 32'(vecs[i].exp_first));
      check($sformatf("vec%0d last_out", i), 32'(last_out), 32'(vecs[i].exp_last));
      check($sformatf("vec%0d pix_idx", i), 32'(pix_idx), 32'(vecs[i].exp_idx));
      if (vecs[i].exp_vout) check($sformatf("vec%0d R", i), 32'(R), 32'(vecs[i].exp_r));
      @(negedge clk);
    end
    do_reset();

    // Single pattern packet, consumer always ready.
    step(1'b1, make_pattern(), 1'b1, acc);
    check("t1 accepted", 32'(acc), 32'd1);
    run_idle(130, 1'b0);
    check("t1 pkt_count", 32'(pkt_count), 32'd1);

    // Same packet with ready_out toggling every cycle.
    step(1'b1, make_pattern(), 1'b1, acc);
    run_idle(258, 1'b1);
    check("t2 pkt_count", 32'(pkt_count), 32'd2);

    // Two constant packets back to back with valid_in held high.
    send_held(make_const(24'h112233), 1'b1);
    send_held(make_const(24'h445566), 1'b1);
    check("t3 handoff idx", 32'(q.size()), 32'(PIXELS));
    run_idle(130, 1'b0);
    check("t3 pkt_count", 32'(pkt_count), 32'd4);

    // New packet offered at pixel 50, held until the pixel-127 handoff.
    step(1'b1, make_pattern(), 1'b1, acc);
    run_to_idx(50);
    send_held(make_random(), 1'b1);
    run_idle(130, 1'b0);

    // Asynchronous reset at pixel 64, mid-cycle.
    step(1'b1, make_pattern(), 1'b1, acc);
    run_to_idx(64);
    valid_in  = 1'b0;
    ready_out = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    check("t5 valid_out", 32'(valid_out), 32'd0);
    check("t5 ready_in", 32'(ready_in), 32'd1);
    check("t5 pix_idx", 32'(pix_idx), 32'd0);
    check("t5 pkt_count", 32'(pkt_count), 32'd0);
    check("t5 RGB", 32'({R, G, B}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    q.delete();
    model_cnt = '0;
    step(1'b1, make_pattern(), 1'b1, acc);
    run_idle(130, 1'b0);
    check("t5 pkt_count after", 32'(pkt_count), 32'd1);

    // Counter wrap from 0xFFFF.
    force dut.pkt_cnt_q = 16'hFFFF;
    #1;
    release dut.pkt_cnt_q;
    model_cnt = 16'hFFFF;
    step(1'b1, make_random(), 1'b1, acc);
    run_idle(130, 1'b0);
    check("t6 pkt_count wrap", 32'(pkt_count), 32'd0);

    // Random traffic: packets held until accepted, random backpressure.
    hv = 1'b0;
    hd = '0;
    for (int i = 0; i < 4000; i++) begin
      if (!hv && $urandom_range(0, 3) == 0) begin
        hv = 1'b1;
        hd = make_random();
      end
      step(hv, hd, logic'($urandom_range(0, 3) != 0), acc);
      if (acc) hv = 1'b0;
    end
    run_idle(300, 1'b0);
    check("random drained", 32'(valid_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", n_err, n_checks);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rgb_packet_unpacker.md
Name: rgb_packet_unpacker

Overview:
- Inverse of the camera-path RGB packer: accepts a 3072-bit packet holding 128 packed 24-bit RGB pixels and replays it as a pixel stream, one pixel per accepted cycle.
- Sits between the packet transport/buffer and pixel-rate consumers (display, ISP re-entry, loopback check).
- Valid/ready handshake on both sides; back-to-back packets with zero bubble.

Parameters:
- PIXELS, 128, pixels per packet (must be ≥2)
- PIX_W, 24, bits per pixel, {R[23:16], G[15:8], B[7:0]}
- PKT_W, PIXELS*PIX_W (3072), packet width, derived; not overridden

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- data_in  in  PKT_W  packet; pixel i at data_in[i*PIX_W +: PIX_W]
- valid_in  in  1  data_in valid
- ready_in  out  1  unpacker can take a packet this cycle
- R  out  8  current pixel red
- G  out  8  current pixel green
- B  out  8  current pixel blue
- valid_out  out  1  R/G/B valid
- ready_out  in  1  downstream accepts pixel
- first_out  out  1  current pixel is pixel 0 of packet
- last_out  out  1  current pixel is pixel PIXELS-1
- pix_idx  out  7  index of current pixel (clog2(PIXELS))
- pkt_count  out  16  packets fully emitted, wraps 0xFFFF→0

Behaviour:
- Reset (async assert, sync release): state IDLE; shift buffer, R/G/B, pix_idx, pkt_count = 0; valid_out, first_out, last_out = 0; ready_in = 1.
- States: IDLE (no packet held), STREAM (packet held, emitting).
- Packet accept = valid_in & ready_in at rising edge. Pixel accept = valid_out & ready_out at rising edge.
- ready_in = (state==IDLE) | (pix_idx==PIXELS-1 & valid_out & ready_out). Combinational from ready_out; no other comb paths input→output.
- IDLE: packet accept → load data_in into buffer, pix_idx=0, → STREAM. Pixel 0 visible with valid_out=1 the cycle after accept (latency 1).
- STREAM: valid_out=1 continuously; R/G/B = buffer[23:0] fields, stable while ready_out=0 (no change of any output under stall).
- STREAM pixel accept, pix_idx<PIXELS-1: buffer shifts right PIX_W, pix_idx+1.
- STREAM pixel accept, pix_idx==PIXELS-1: pkt_count+1; if simultaneous packet accept → reload buffer, pix_idx=0, stay STREAM (no bubble); else → IDLE, valid_out=0.
- first_out = valid_out & pix_idx==0; last_out = valid_out & pix_idx==PIXELS-1.
- valid_in while ready_in=0: ignored, packet not consumed; upstream must hold data_in/valid_in stable until accepted.
- Emission order: pixel 0 (LSBs) first, pixel PIXELS-1 last.
- rst mid-packet: remaining pixels discarded, outputs immediately to reset values; no partial packet counted.
- valid_out never drops inside a packet regardless of ready_out.

Test Plan:
- Reset then data_in with pixel i = {i[7:0], ~i[7:0], 8'hA5}, valid_in 1 cycle, ready_out=1 → ready_in falls, next 128 cycles emit R=i, G=~i, B=A5 for i=0..127; first_out at i=0, last_out at i=127; pkt_count=1; valid_out=0 after.
- Same packet, ready_out toggled 1/0 each cycle → 128 pixels in 255 cycles; R/G/B/pix_idx held on stall cycles; order unchanged.
- Two packets (all-pixels 0x112233, then 0x445566), valid_in held high → 256 consecutive valid cycles, no gap; 2nd packet accepted on cycle with pix_idx=127; pkt_count=2.
- valid_in=1 with new data at pix_idx=50 → ready_in=0, not accepted; accepted only at pix_idx=127 handoff; first packet data uncorrupted.
- rst asserted at pix_idx=64 asynchronously (mid-cycle) → valid_out=0, ready_in=1, pix_idx=0, pkt_count unchanged-from-reset (0) immediately; next packet emits from pixel 0.
- Force pkt_count to 0xFFFF (65535 packets or backdoor) then complete one packet → pkt_count=0x0000.
